// File: rtl/adder_pkg.sv
// adder_pkg: stage-count and slice-offset helpers for the pipelined CLA adder
package adder_pkg;

    function automatic int stage_count(input int width, input int slice);
        return (slice > 0) ? width / slice : 1;
    endfunction

    function automatic int slice_lo(input int k, input int slice);
        return k * slice;
    endfunction

endpackage

// File: rtl/cla_slice.sv
// cla_slice: combinational SLICE-bit carry-lookahead group with group generate/propagate
module cla_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             g,
    output logic             p
);
    logic [SLICE-1:0] w_g, w_p;
    logic [SLICE:0]   w_c;
    logic             w_acc, w_t;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // each carry is the fully expanded sum of products, not a ripple chain
    always_comb begin
        w_c   = '0;
        w_acc = 1'b0;
        w_t   = 1'b0;
        g     = 1'b0;
        w_c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            w_acc = w_g[i];
            w_t   = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_acc = w_acc | (w_t & w_g[j]);
                w_t   = w_t & w_p[j];
            end
            if (i == SLICE - 1) g = w_acc;
            w_c[i+1] = w_acc | (w_t & cin);
        end
    end

    assign p    = &w_p;
    assign s    = w_p ^ w_c[SLICE-1:0];
    assign cout = w_c[SLICE];

endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: carry-pipelined CLA adder/subtractor, one SLICE-bit group per stage
module pipelined_cla_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             overFlow,
    output logic             Zero
);
    localparam int STAGES = stage_count(WIDTH, SLICE);

    logic             w_en;
    logic             w_c0;
    logic [WIDTH-1:0] w_bx;

    if (SLICE < 1 || SLICE > WIDTH || WIDTH % SLICE != 0) begin : g_bad_cfg
        $error("pipelined_cla_adder: WIDTH must be a positive multiple of SLICE");
    end

    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;
    assign w_bx     = Sub ? ~B : B;
    assign w_c0     = Sub ? ~Cin : Cin;

    // stage k consumes the low slice of the remaining operands and prepends its sum slice
    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = slice_lo(k, SLICE);
        logic [WIDTH-LO-1:0] w_pa, w_pb;
        logic [LO+SLICE-1:0] w_ns;
        logic [LO+SLICE-1:0] r_s;
        logic [SLICE-1:0]    w_sum;
        logic [1:0]          w_unused_gp;
        logic                w_pv, w_cin, w_co;
        logic                r_v, r_c;

        if (k == 0) begin : g_first
            assign w_pa  = A;
            assign w_pb  = w_bx;
            assign w_pv  = in_valid;
            assign w_cin = w_c0;
            assign w_ns  = w_sum;
        end else begin : g_next
            assign w_pa  = g_st[k-1].g_fwd.r_a;
            assign w_pb  = g_st[k-1].g_fwd.r_b;
            assign w_pv  = g_st[k-1].r_v;
            assign w_cin = g_st[k-1].r_c;
            assign w_ns  = {w_sum, g_st[k-1].r_s};
        end

        cla_slice #(.SLICE(SLICE)) u_slice (
            .a    (w_pa[SLICE-1:0]),
            .b    (w_pb[SLICE-1:0]),
            .cin  (w_cin),
            .s    (w_sum),
            .cout (w_co),
            .g    (w_unused_gp[0]),
            .p    (w_unused_gp[1])
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_en) begin
                r_v <= w_pv;
                r_c <= w_co;
                r_s <= w_ns;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-LO-SLICE-1:0] r_a, r_b;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_en) begin
                    r_a <= w_pa[WIDTH-LO-1:SLICE];
                    r_b <= w_pb[WIDTH-LO-1:SLICE];
                end
            end
        end

        // the top slice still carries the A/Bx sign bits, so flags are formed here
        if (k == STAGES - 1) begin : g_last
            logic r_ov, r_z;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ov <= 1'b0;
                    r_z  <= 1'b0;
                end else if (w_en) begin
                    r_ov <= (w_pa[SLICE-1] == w_pb[SLICE-1]) && (w_sum[SLICE-1] != w_pa[SLICE-1]);
                    r_z  <= ~|w_ns;
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].r_v;
    assign S         = g_st[STAGES-1].r_s;
    assign Cout      = g_st[STAGES-1].r_c;
    assign overFlow  = g_st[STAGES-1].g_last.r_ov;
    assign Zero      = g_st[STAGES-1].g_last.r_z;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: scoreboard bench with hand-computed directed vectors
module tb_pipelined_cla_adder;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        logic         z;
    } vec_t;

    logic         clk = 1'b0, rst = 1'b1;
    logic         in_valid = 1'b0, in_ready, out_valid, out_ready;
    logic [W-1:0] A = '0, B = '0, S;
    logic         Cin = 1'b0, Sub = 1'b0, Cout, overFlow, Zero;

    int           n_cmp = 0, n_fail = 0;
    bit           pat_en = 1'b0, chk_en = 1'b0;
    logic [34:0]  q[$];
    vec_t         v[16];
    bit           pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    pipelined_cla_adder #(.WIDTH(W), .SLICE(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Sub       (Sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .overFlow  (overFlow),
        .Zero      (Zero)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    initial begin
        int c = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = pat_en ? pat[c % 6] : 1'b1;
            if (pat_en) c++;
        end
    end

    always @(negedge clk) begin : monitor
        logic [34:0] e;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) chk("spurious_output", {63'd0, out_valid}, 64'd0);
            else begin
                e = q.pop_front();
                chk("result", {29'd0, S, Cout, overFlow, Zero}, {29'd0, e});
            end
        end
    end

    always @(negedge clk) begin : flow
        bit          stall_prev;
        logic [35:0] held;
        if (!rst && chk_en) begin
            chk("in_ready", {63'd0, in_ready}, {63'd0, !out_valid || out_ready});
            if (stall_prev) chk("stall_hold", {28'd0, out_valid, S, Cout, overFlow, Zero}, {28'd0, held});
            stall_prev = out_valid && !out_ready;
            held = {out_valid, S, Cout, overFlow, Zero};
        end else stall_prev = 1'b0;
    end

    task automatic issue(input int i);
        int n = 0;
        bit done = 1'b0;
        A = v[i].a;
        B = v[i].b;
        Cin = v[i].cin;
        Sub = v[i].sub;
        in_valid = 1'b1;
        while (!done && n < 100) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back({v[i].s, v[i].co, v[i].ov, v[i].z});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        chk("issue_timeout", {63'd0, done}, 64'd1);
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while (q.size() != 0 && n < lim) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int n;
        v = '{
            '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1},
            '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0},
            '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1},
            '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0},
            '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0, 1'b0},
            '{32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h01000000, 1'b0, 1'b0, 1'b0},
            '{32'hFFFFFF00, 32'h00000100, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1},
            '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0},
            '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0},
            '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1},
            '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0},
            '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0},
            '{32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0, 32'h0001FFFE, 1'b0, 1'b0, 1'b0},
            '{32'h40000000, 32'h40000000, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0},
            '{32'h00000010, 32'h00000010, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0},
            '{32'hDEADBEEF, 32'h00000000, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0}
        };
        #12;
        chk("reset_outputs", {28'd0, out_valid, S, Cout, overFlow, Zero}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            issue(i);
            in_valid = 1'b0;
            drain(50);
        end

        pat_en = 1'b1;
        for (int i = 0; i < 16; i++) issue(i);
        in_valid = 1'b0;
        drain(300);
        pat_en = 1'b0;
        @(posedge clk);
        #1;

        // three operations in flight when reset hits mid-cycle
        issue(7);
        issue(8);
        issue(9);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", {28'd0, out_valid, S, Cout, overFlow, Zero}, 64'd0);
        chk("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("no_result_after_rst", {63'd0, out_valid}, 64'd0);

        A = v[5].a;
        B = v[5].b;
        Cin = v[5].cin;
        Sub = v[5].sub;
        in_valid = 1'b1;
        @(negedge clk);
        chk("accept_ready", {63'd0, in_ready}, 64'd1);
        q.push_back({v[5].s, v[5].co, v[5].ov, v[5].z});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 64'(n), 64'd4);
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end

endmodule
